// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: captures the decoded control bundle and operands, with freeze, flush and valid tracking.
// Optional build macro ID_EXE_PERF_CNT_EN adds saturating instruction/bubble counters.
module id_exe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  WB_EN_in,
  input  logic                  MEM_R_EN_in,
  input  logic                  MEM_W_EN_in,
  input  logic                  B_in,
  input  logic                  S_in,
  input  logic [3:0]            EXE_CMD_in,
  input  logic [DATA_W-1:0]     PC_in,
  input  logic [DATA_W-1:0]     Val_Rn_in,
  input  logic [DATA_W-1:0]     Val_Rm_in,
  input  logic                  imm_in,
  input  logic [11:0]           Shift_operand_in,
  input  logic [23:0]           Signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] Dest_in,
  input  logic [REG_ADDR_W-1:0] Src1_in,
  input  logic [REG_ADDR_W-1:0] Src2_in,
  input  logic                  C_in,
  output logic                  valid_out,
  output logic                  WB_EN_out,
  output logic                  MEM_R_EN_out,
  output logic                  MEM_W_EN_out,
  output logic                  B_out,
  output logic                  S_out,
  output logic [3:0]            EXE_CMD_out,
  output logic [DATA_W-1:0]     PC_out,
  output logic [DATA_W-1:0]     Val_Rn_out,
  output logic [DATA_W-1:0]     Val_Rm_out,
  output logic                  imm_out,
  output logic [11:0]           Shift_operand_out,
  output logic [23:0]           Signed_imm_24_out,
  output logic [REG_ADDR_W-1:0] Dest_out,
  output logic [REG_ADDR_W-1:0] Src1_out,
  output logic [REG_ADDR_W-1:0] Src2_out,
  output logic                  C_out,
  output logic [CNT_W-1:0]      perf_instr_cnt,
  output logic [CNT_W-1:0]      perf_bubble_cnt
);

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  b;
    logic                  s;
    logic [3:0]            exe_cmd;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     val_rn;
    logic [DATA_W-1:0]     val_rm;
    logic                  imm;
    logic [11:0]           shift_operand;
    logic [23:0]           signed_imm_24;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  c;
  } stage_t;

  stage_t next_s;
  stage_t stage_r;
  logic   update_s;

  // Flush overrides freeze; otherwise a freeze holds every register.
  assign update_s = flush | ~freeze;

  // Next stage contents: a full bubble on flush, else the decode bundle with enables gated by valid_in.
  always_comb begin
    next_s = '0;
    if (flush) begin
      next_s = '0;
    end else begin
      next_s.valid         = valid_in;
      next_s.wb_en         = WB_EN_in & valid_in;
      next_s.mem_r_en      = MEM_R_EN_in & valid_in;
      next_s.mem_w_en      = MEM_W_EN_in & valid_in;
      next_s.b             = B_in & valid_in;
      next_s.s             = S_in & valid_in;
      next_s.exe_cmd       = EXE_CMD_in;
      next_s.pc            = PC_in;
      next_s.val_rn        = Val_Rn_in;
      next_s.val_rm        = Val_Rm_in;
      next_s.imm           = imm_in;
      next_s.shift_operand = Shift_operand_in;
      next_s.signed_imm_24 = Signed_imm_24_in;
      next_s.dest          = Dest_in;
      next_s.src1          = Src1_in;
      next_s.src2          = Src2_in;
      next_s.c             = C_in;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= '0;
    end else if (update_s) begin
      stage_r <= next_s;
    end else begin
      stage_r <= stage_r;
    end
  end

  assign valid_out         = stage_r.valid;
  assign WB_EN_out         = stage_r.wb_en;
  assign MEM_R_EN_out      = stage_r.mem_r_en;
  assign MEM_W_EN_out      = stage_r.mem_w_en;
  assign B_out             = stage_r.b;
  assign S_out             = stage_r.s;
  assign EXE_CMD_out       = stage_r.exe_cmd;
  assign PC_out            = stage_r.pc;
  assign Val_Rn_out        = stage_r.val_rn;
  assign Val_Rm_out        = stage_r.val_rm;
  assign imm_out           = stage_r.imm;
  assign Shift_operand_out = stage_r.shift_operand;
  assign Signed_imm_24_out = stage_r.signed_imm_24;
  assign Dest_out          = stage_r.dest;
  assign Src1_out          = stage_r.src1;
  assign Src2_out          = stage_r.src2;
  assign C_out             = stage_r.c;

`ifdef ID_EXE_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  // Saturating counters: each non-frozen edge counts either a real instruction or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_r  <= '0;
      bubble_cnt_r <= '0;
    end else if (update_s) begin
      if (valid_in && !flush) begin
        if (instr_cnt_r != {CNT_W{1'b1}}) begin
          instr_cnt_r <= instr_cnt_r + CNT_W'(1);
        end
      end else if (bubble_cnt_r != {CNT_W{1'b1}}) begin
        bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
      end
    end
  end

  assign perf_instr_cnt  = instr_cnt_r;
  assign perf_bubble_cnt = bubble_cnt_r;
`else
  assign perf_instr_cnt  = {CNT_W{1'b0}};
  assign perf_bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: randomized stimulus against a bundle-level reference model.
module tb_id_exe_stage_reg;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ID_EXE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic        valid, wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest, src1, src2;
    logic        c;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n, freeze, flush, valid_in;
  logic WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, imm_in, C_in;
  logic [3:0]  EXE_CMD_in, Dest_in, Src1_in, Src2_in;
  logic [31:0] PC_in, Val_Rn_in, Val_Rm_in;
  logic [11:0] Shift_operand_in;
  logic [23:0] Signed_imm_24_in;
  logic valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, imm_out, C_out;
  logic [3:0]  EXE_CMD_out, Dest_out, Src1_out, Src2_out;
  logic [31:0] PC_out, Val_Rn_out, Val_Rm_out;
  logic [11:0] Shift_operand_out;
  logic [23:0] Signed_imm_24_out;
  logic [CNT_W-1:0] perf_instr_cnt, perf_bubble_cnt;

  bundle_t exp_b;
  int exp_instr, exp_bubble;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .B_in(B_in), .S_in(S_in), .EXE_CMD_in(EXE_CMD_in), .PC_in(PC_in),
    .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in), .imm_in(imm_in),
    .Shift_operand_in(Shift_operand_in), .Signed_imm_24_in(Signed_imm_24_in),
    .Dest_in(Dest_in), .Src1_in(Src1_in), .Src2_in(Src2_in), .C_in(C_in),
    .valid_out(valid_out), .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
    .MEM_W_EN_out(MEM_W_EN_out), .B_out(B_out), .S_out(S_out),
    .EXE_CMD_out(EXE_CMD_out), .PC_out(PC_out), .Val_Rn_out(Val_Rn_out),
    .Val_Rm_out(Val_Rm_out), .imm_out(imm_out), .Shift_operand_out(Shift_operand_out),
    .Signed_imm_24_out(Signed_imm_24_out), .Dest_out(Dest_out), .Src1_out(Src1_out),
    .Src2_out(Src2_out), .C_out(C_out),
    .perf_instr_cnt(perf_instr_cnt), .perf_bubble_cnt(perf_bubble_cnt)
  );

  function automatic bundle_t in_bundle();
    return bundle_t'({valid_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, EXE_CMD_in,
                      PC_in, Val_Rn_in, Val_Rm_in, imm_in, Shift_operand_in, Signed_imm_24_in,
                      Dest_in, Src1_in, Src2_in, C_in});
  endfunction

  function automatic bundle_t out_bundle();
    return bundle_t'({valid_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, B_out, S_out, EXE_CMD_out,
                      PC_out, Val_Rn_out, Val_Rm_out, imm_out, Shift_operand_out, Signed_imm_24_out,
                      Dest_out, Src1_out, Src2_out, C_out});
  endfunction

  // Reference behaviour of one rising edge, from the architectural rules.
  task automatic model_edge();
    bundle_t nb;
    bit counted;
    counted = flush || !freeze;
    if (flush) begin
      exp_b = '0;
    end else if (!freeze) begin
      nb = in_bundle();
      if (!nb.valid) begin
        nb.wb = 1'b0; nb.mr = 1'b0; nb.mw = 1'b0; nb.b = 1'b0; nb.s = 1'b0;
      end
      exp_b = nb;
    end
    if (PERF && counted) begin
      if (valid_in && !flush) exp_instr = (exp_instr < CNT_MAX) ? exp_instr + 1 : exp_instr;
      else exp_bubble = (exp_bubble < CNT_MAX) ? exp_bubble + 1 : exp_bubble;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs();
    {WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, imm_in, C_in} = 7'($urandom);
    EXE_CMD_in = 4'($urandom); Dest_in = 4'($urandom);
    Src1_in = 4'($urandom); Src2_in = 4'($urandom);
    PC_in = $urandom; Val_Rn_in = $urandom; Val_Rm_in = $urandom;
    Shift_operand_in = 12'($urandom); Signed_imm_24_in = 24'($urandom);
  endtask

  task automatic apply_reset_between_edges();
    #2 rst_n = 1'b0;
    #1;
    exp_b = '0; exp_instr = 0; exp_bubble = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; valid_in = 1'b0;
    rand_inputs();
    exp_b = '0; exp_instr = 0; exp_bubble = 0;
    #2;
    checks++;
    if (out_bundle() !== bundle_t'('0)) begin
      fails++; $display("FAIL reset_bundle: got %h expected 0", out_bundle());
    end
    checks++;
    if (perf_instr_cnt !== 4'd0 || perf_bubble_cnt !== 4'd0) begin
      fails++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", perf_instr_cnt, perf_bubble_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset_async();
    rand_inputs(); valid_in = 1'b1; EXE_CMD_in = 4'b0011; Dest_in = 4'd5; WB_EN_in = 1'b1;
    step();
    checks++;
    if (valid_out !== 1'b1 || Dest_out !== 4'd5 || EXE_CMD_out !== 4'b0011 || WB_EN_out !== 1'b1) begin
      fails++; $display("FAIL add_load: got %h expected %h", out_bundle(), exp_b);
    end
    apply_reset_between_edges();
    checks++;
    if (out_bundle() !== bundle_t'('0) || perf_instr_cnt !== 4'd0 || perf_bubble_cnt !== 4'd0) begin
      fails++; $display("FAIL async_reset: got %h cnt %0d/%0d expected 0", out_bundle(), perf_instr_cnt, perf_bubble_cnt);
    end
    #2 rst_n = 1'b1;
    rand_inputs(); valid_in = 1'b1;
    step();
    freeze = 1'b1; rand_inputs();
    step();
    apply_reset_between_edges();
    checks++;
    if (out_bundle() !== bundle_t'('0) || perf_instr_cnt !== 4'd0) begin
      fails++; $display("FAIL reset_mid_freeze: got %h cnt %0d expected 0", out_bundle(), perf_instr_cnt);
    end
    #2 rst_n = 1'b1; freeze = 1'b0;
  endtask

  task automatic test_normal();
    rand_inputs(); valid_in = 1'b1; EXE_CMD_in = 4'b0010; Val_Rn_in = 32'h10;
    PC_in = 32'h104; MEM_R_EN_in = 1'b1;
    step();
    checks++;
    if (valid_out !== 1'b1 || EXE_CMD_out !== 4'b0010 || Val_Rn_out !== 32'h10 ||
        PC_out !== 32'h104 || MEM_R_EN_out !== 1'b1 || out_bundle() !== exp_b) begin
      fails++; $display("FAIL normal_flow: got %h expected %h", out_bundle(), exp_b);
    end
  endtask

  task automatic test_freeze();
    logic [CNT_W-1:0] i0, b0;
    rand_inputs(); valid_in = 1'b1; Dest_in = 4'd7;
    step();
    i0 = perf_instr_cnt; b0 = perf_bubble_cnt;
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_inputs(); Dest_in = 4'd9; valid_in = 1'($urandom);
      step();
      checks++;
      if (Dest_out !== 4'd7 || out_bundle() !== exp_b || perf_instr_cnt !== i0 || perf_bubble_cnt !== b0) begin
        fails++; $display("FAIL freeze_hold: Dest got %0d expected 7, cnt %0d/%0d expected %0d/%0d",
                          Dest_out, perf_instr_cnt, perf_bubble_cnt, i0, b0);
      end
    end
    freeze = 1'b0; valid_in = 1'b1;
    step();
    checks++;
    if (Dest_out !== 4'd9 || out_bundle() !== exp_b) begin
      fails++; $display("FAIL freeze_release: Dest got %0d expected 9", Dest_out);
    end
  endtask

  task automatic test_flush();
    rand_inputs(); valid_in = 1'b1;
    step();
    freeze = 1'b1; flush = 1'b1; rand_inputs(); WB_EN_in = 1'b1; B_in = 1'b1;
    step();
    checks++;
    if (valid_out !== 1'b0 || WB_EN_out !== 1'b0 || B_out !== 1'b0 || EXE_CMD_out !== 4'd0 ||
        PC_out !== 32'd0 || out_bundle() !== bundle_t'('0)) begin
      fails++; $display("FAIL flush_over_freeze: got %h expected 0", out_bundle());
    end
    freeze = 1'b0; flush = 1'b0;
  endtask

  task automatic test_invalid_gating();
    rand_inputs(); valid_in = 1'b0; MEM_W_EN_in = 1'b1; Val_Rm_in = 32'hAB;
    WB_EN_in = 1'b1; B_in = 1'b1; S_in = 1'b1; MEM_R_EN_in = 1'b1;
    step();
    checks++;
    if (MEM_W_EN_out !== 1'b0 || Val_Rm_out !== 32'hAB || valid_out !== 1'b0 || WB_EN_out !== 1'b0 ||
        B_out !== 1'b0 || S_out !== 1'b0 || MEM_R_EN_out !== 1'b0 || Dest_out !== Dest_in) begin
      fails++; $display("FAIL invalid_gating: got %h expected %h", out_bundle(), exp_b);
    end
  endtask

  task automatic test_counters();
    apply_reset_between_edges();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin rand_inputs(); valid_in = 1'b1; step(); end
    flush = 1'b1;
    for (int k = 0; k < 2; k++) begin rand_inputs(); valid_in = 1'b1; step(); end
    flush = 1'b0; freeze = 1'b1; valid_in = 1'b0;
    step();
    freeze = 1'b0;
    checks++;
    if (perf_instr_cnt !== (PERF ? 4'd4 : 4'd0) || perf_bubble_cnt !== (PERF ? 4'd2 : 4'd0)) begin
      fails++; $display("FAIL counters_mix: got %0d/%0d expected %0d/%0d", perf_instr_cnt, perf_bubble_cnt,
                        PERF ? 4 : 0, PERF ? 2 : 0);
    end
    for (int k = 0; k < 20; k++) begin rand_inputs(); valid_in = 1'b1; step(); end
    checks++;
    if (perf_instr_cnt !== (PERF ? 4'd15 : 4'd0) || perf_bubble_cnt !== (PERF ? 4'd2 : 4'd0)) begin
      fails++; $display("FAIL counters_saturate: got %0d/%0d expected %0d/%0d", perf_instr_cnt, perf_bubble_cnt,
                        PERF ? 15 : 0, PERF ? 2 : 0);
    end
  endtask

  task automatic test_random();
    apply_reset_between_edges();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      rand_inputs();
      valid_in = ($urandom_range(0, 3) != 0);
      freeze   = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 5) == 0);
      step();
      checks++;
      if (out_bundle() !== exp_b) begin
        fails++; $display("FAIL random_bundle[%0d]: got %h expected %h", k, out_bundle(), exp_b);
      end
      checks++;
      if (perf_instr_cnt !== CNT_W'(exp_instr) || perf_bubble_cnt !== CNT_W'(exp_bubble)) begin
        fails++; $display("FAIL random_counters[%0d]: got %0d/%0d expected %0d/%0d", k,
                          perf_instr_cnt, perf_bubble_cnt, exp_instr, exp_bubble);
      end
    end
    freeze = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_async();
    test_normal();
    test_freeze();
    test_flush();
    test_invalid_gating();
    test_counters();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
